// File: rtl/secded_72_64_decoder_if.sv
// Stream bundle between the ECC decoder and its neighbours: codeword in, corrected word out.
// The decoder drives the slave side; the producer/consumer pair drives the master side.
interface secded_72_64_decoder_if;
   logic        in_valid;
   logic        in_ready;
   logic [71:0] IN;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] OUT;
   logic        err_ce;
   logic        err_ue;
   logic [6:0]  syndrome;

   modport master (
      output in_valid, IN, out_ready,
      input  in_ready, out_valid, OUT, err_ce, err_ue, syndrome
   );

   modport slave (
      input  in_valid, IN, out_ready,
      output in_ready, out_valid, OUT, err_ce, err_ue, syndrome
   );
endinterface

// File: rtl/secded_72_64_decoder.sv
// (72,64) SECDED decoder: corrects single-bit errors and flags double errors, with saturating counters.
// Two-stage pipeline, 2-cycle latency; both stages hold while out_valid && !out_ready, and then in_ready=0.
module secded_72_64_decoder #(
   parameter int CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   secded_72_64_decoder_if.slave bus,
   input  logic                 clr_cnt,
   output logic [CNT_W-1:0]     ce_count,
   output logic [CNT_W-1:0]     ue_count,
   output logic                 ue_log_valid,
   output logic [6:0]           ue_log_syn
);

   function automatic logic [6:0] calc_syn(input logic [71:0] cw);
      logic [6:0] s;
      logic [6:0] pos;
      s = '0;
      for (int i = 1; i < 72; i++) begin
         pos = 7'(i);
         for (int k = 0; k < 7; k++) begin
            if (pos[k]) s[k] = s[k] ^ cw[i];
         end
      end
      return s;
   endfunction

   // Data occupies every non-power-of-two position from 3 upward, in ascending order.
   function automatic logic [63:0] extract(input logic [71:0] cw);
      logic [63:0] d;
      logic [6:0]  pos;
      logic [5:0]  j;
      d = '0;
      j = '0;
      for (int i = 3; i < 72; i++) begin
         pos = 7'(i);
         if ((pos & (pos - 7'd1)) != 7'd0) begin
            d[j] = cw[i];
            j    = j + 6'd1;
         end
      end
      return d;
   endfunction

   logic             advance;
   logic             xfer_out;
   logic             s1_vld_q, s1_vld_d;
   logic [71:0]      s1_cw_q, s1_cw_d;
   logic [6:0]       s1_syn_q, s1_syn_d;
   logic             s1_par_q, s1_par_d;
   logic             out_vld_q, out_vld_d;
   logic [63:0]      out_dat_q, out_dat_d;
   logic             ce_q, ce_d;
   logic             ue_q, ue_d;
   logic [6:0]       syn_q, syn_d;
   logic [CNT_W-1:0] ce_cnt_q, ce_cnt_d;
   logic [CNT_W-1:0] ue_cnt_q, ue_cnt_d;
   logic             log_vld_q, log_vld_d;
   logic [6:0]       log_syn_q, log_syn_d;
   logic             is_ce;
   logic             is_ue;
   logic [71:0]      cw_fix;

   assign advance      = !out_vld_q || bus.out_ready;
   assign xfer_out     = out_vld_q && bus.out_ready;
   assign bus.in_ready = advance;

   always_comb begin
      s1_vld_d = s1_vld_q;
      s1_cw_d  = s1_cw_q;
      s1_syn_d = s1_syn_q;
      s1_par_d = s1_par_q;
      if (advance) begin
         s1_vld_d = bus.in_valid;
         if (bus.in_valid) begin
            s1_cw_d  = bus.IN;
            s1_syn_d = calc_syn(bus.IN);
            s1_par_d = ^bus.IN;
         end
      end
   end

   // Odd parity with an in-range syndrome is a single flip; anything else non-clean is uncorrectable.
   always_comb begin
      is_ce  = s1_par_q && (s1_syn_q <= 7'd71);
      is_ue  = s1_par_q ? (s1_syn_q > 7'd71) : (s1_syn_q != 7'd0);
      cw_fix = is_ce ? (s1_cw_q ^ (72'd1 << s1_syn_q)) : s1_cw_q;
   end

   always_comb begin
      out_vld_d = out_vld_q;
      out_dat_d = out_dat_q;
      ce_d      = ce_q;
      ue_d      = ue_q;
      syn_d     = syn_q;
      if (advance) begin
         out_vld_d = s1_vld_q;
         if (s1_vld_q) begin
            out_dat_d = extract(cw_fix);
            ce_d      = is_ce;
            ue_d      = is_ue;
            syn_d     = s1_syn_q;
         end
      end
   end

   always_comb begin
      ce_cnt_d  = ce_cnt_q;
      ue_cnt_d  = ue_cnt_q;
      log_vld_d = log_vld_q;
      log_syn_d = log_syn_q;
      if (clr_cnt) begin
         ce_cnt_d  = '0;
         ue_cnt_d  = '0;
         log_vld_d = 1'b0;
         log_syn_d = '0;
      end else if (xfer_out) begin
         if (ce_q && (ce_cnt_q != {CNT_W{1'b1}})) ce_cnt_d = ce_cnt_q + CNT_W'(1);
         if (ue_q && (ue_cnt_q != {CNT_W{1'b1}})) ue_cnt_d = ue_cnt_q + CNT_W'(1);
         if (ue_q && !log_vld_q) begin
            log_vld_d = 1'b1;
            log_syn_d = syn_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_vld_q  <= 1'b0;
         s1_cw_q   <= '0;
         s1_syn_q  <= '0;
         s1_par_q  <= 1'b0;
         out_vld_q <= 1'b0;
         out_dat_q <= '0;
         ce_q      <= 1'b0;
         ue_q      <= 1'b0;
         syn_q     <= '0;
         ce_cnt_q  <= '0;
         ue_cnt_q  <= '0;
         log_vld_q <= 1'b0;
         log_syn_q <= '0;
      end else begin
         s1_vld_q  <= s1_vld_d;
         s1_cw_q   <= s1_cw_d;
         s1_syn_q  <= s1_syn_d;
         s1_par_q  <= s1_par_d;
         out_vld_q <= out_vld_d;
         out_dat_q <= out_dat_d;
         ce_q      <= ce_d;
         ue_q      <= ue_d;
         syn_q     <= syn_d;
         ce_cnt_q  <= ce_cnt_d;
         ue_cnt_q  <= ue_cnt_d;
         log_vld_q <= log_vld_d;
         log_syn_q <= log_syn_d;
      end
   end

   assign bus.out_valid = out_vld_q;
   assign bus.OUT       = out_dat_q;
   assign bus.err_ce    = ce_q;
   assign bus.err_ue    = ue_q;
   assign bus.syndrome  = syn_q;
   assign ce_count      = ce_cnt_q;
   assign ue_count      = ue_cnt_q;
   assign ue_log_valid  = log_vld_q;
   assign ue_log_syn    = log_syn_q;

endmodule

// File: doc/secded_72_64_decoder.md
Name: secded_72_64_decoder

Overview:
- Receive end of the cache ECC path: takes 72-bit (72,64) extended-Hamming codewords, which may have been corrupted by the fault injector.
- Computes syndrome and overall parity, corrects any single-bit error, and flags double-bit errors.
- Two-stage pipeline with valid/ready handshake, saturating error counters and a sticky first-uncorrectable-error log, readable by the cache controller.

Parameters:
- CNT_W, 16, width of the correctable/uncorrectable error counters (min 2)

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  codeword present on IN
- in_ready  output  1  decoder can accept IN this cycle
- IN  input  72  received codeword, bit i = Hamming position i
- out_valid  output  1  decoded word present
- out_ready  input  1  downstream accepts the output
- OUT  output  64  corrected data
- err_ce  output  1  beat had a corrected single-bit error
- err_ue  output  1  beat is uncorrectable; OUT = raw extracted data
- syndrome  output  7  syndrome of the beat on OUT
- clr_cnt  input  1  synchronous clear of counters and log
- ce_count  output  CNT_W  saturating count of CE beats delivered
- ue_count  output  CNT_W  saturating count of UE beats delivered
- ue_log_valid  output  1  the log holds the first UE since clear
- ue_log_syn  output  7  syndrome of the first UE since clear

Behaviour:
- Code layout:
  - Position 0 = overall parity.
  - Positions 1,2,4,8,16,32,64 = Hamming parity bits.
  - Data bits fill the remaining positions in ascending order: data[0]=pos 3, data[1]=pos 5, data[2]=pos 6, data[3]=pos 7, data[4]=pos 9, ..., data[63]=pos 71.
- Syndrome: s[k] = XOR of IN[i] over every i in 1..71 with bit k of i set. p = XOR of all 72 bits.
- Classification:
  - s=0, p=0: clean.
  - p=1, s<=71: CE; flip IN[s] (s=0 flips only the overall-parity bit, so data is unchanged).
  - p=0, s!=0: UE (double error).
  - p=1, s>71: UE (multi-bit).
- Pipeline stages:
  - Stage 1 registers the codeword, s and p.
  - Stage 2 registers the corrected data, err_ce, err_ue and syndrome.
  - err_ce and err_ue are never both 1.
- Flow control:
  - advance = !out_valid || out_ready; in_ready = advance (combinational from out_valid and out_ready).
  - Both stages shift only on advance. A transfer occurs on in_valid && in_ready.
  - A stage-1 bubble is filled with valid=0.
  - Latency 2 cycles from input transfer to out_valid when out_ready is held 1. Throughput 1 beat/cycle.
- Stall behaviour: while out_valid=1 and out_ready=0, OUT, err_*, syndrome and stage 1 hold stable; in_ready=0.
- Counters:
  - On an output transfer (out_valid && out_ready), ce_count increments if err_ce and ue_count increments if err_ue.
  - Both saturate at 2^CNT_W-1 and never wrap.
- UE log: on the first UE output transfer while ue_log_valid=0, capture the syndrome and set ue_log_valid. Later UEs leave the log unchanged.
- clr_cnt:
  - Zeroes both counters and ue_log_valid/ue_log_syn.
  - If an increment or log capture coincides with clr_cnt, clear wins: the result is 0 / invalid.
  - Does not affect the pipeline.
- Reset values: out_valid=0, OUT=0, err_ce=0, err_ue=0, syndrome=0, counters 0, ue_log_valid=0, ue_log_syn=0, stage-1 valid=0.
- Reset mid-operation: in-flight beats are discarded and not counted. in_ready=1 on the first cycle after reset deasserts.
- rst has priority over clr_cnt and all data movement.

Test Plan:
- IN=72'h0, out_ready=1 -> 2 cycles later OUT=0, err_ce=0, err_ue=0, syndrome=0; counters unchanged.
- IN with only bit 3 set -> OUT=64'h0, err_ce=1, syndrome=7'd3, ce_count=1. IN with only bit 0 set -> OUT=0, err_ce=1, syndrome=0.
- IN with bits 3 and 5 set -> err_ue=1, syndrome=7'd6, ue_count=1, ue_log_valid=1, ue_log_syn=6. A following UE with bits 9 and 10 set (syndrome 3) leaves ue_log_syn=6.
- Stream of 4 back-to-back beats with out_ready=0 for cycles 3-5 -> in_ready=0 while stalled, OUT stable, all 4 beats delivered in order with none lost or duplicated.
- CNT_W=2, 5 CE beats -> ce_count stops at 3. Then clr_cnt asserted in the same cycle as a CE transfer -> ce_count=0.
- rst pulsed while 2 beats are in flight -> out_valid=0 next cycle, counters=0, the beats are never output.
